// File: rtl/dmem_bus_master.sv
// MEM-stage data-memory master: turns a load/store into one Wishbone-classic
// transfer, freezing the pipeline while it is outstanding.
module dmem_bus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_mem,
  input  logic        mem_write_mem,
  input  logic [2:0]  fun3_mem,
  input  logic [31:0] addr_mem,
  input  logic [31:0] wdata_mem,
  output logic [31:0] rdata_mem,
  output logic        stall_pipl,
  output logic        misaligned_mem,
  output logic        bus_err_mem,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_e      state_q;
  size_e       size_q;
  logic [7:0]  cnt_q;
  logic        cyc_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req;
  logic        misaligned;
  size_e       size_d;
  logic [3:0]  sel_d;
  logic [31:0] dat_d;
  logic [31:0] shifted;
  logic [31:0] load_data_d;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    req    = mem_read_mem | mem_write_mem;
    size_d = SZ_W;
    sel_d  = 4'b1111;
    dat_d  = wdata_mem;
    // fun3[1:0] alone selects the size; 011/110/111 fall through to W.
    unique case (fun3_mem[1:0])
      2'b00: begin
        size_d = SZ_B;
        sel_d  = 4'b0001 << addr_mem[1:0];
        dat_d  = {4{wdata_mem[7:0]}};
      end
      2'b01: begin
        size_d = SZ_H;
        sel_d  = 4'b0011 << addr_mem[1:0];
        dat_d  = {2{wdata_mem[15:0]}};
      end
      default: ;
    endcase
    misaligned = ((size_d == SZ_H) & addr_mem[0]) |
                 ((size_d == SZ_W) & (|addr_mem[1:0]));

    shifted     = wb_dat_i >> {off_q, 3'b000};
    load_data_d = shifted;
    unique case (size_q)
      SZ_B:    load_data_d = {{24{~uns_q & shifted[7]}},  shifted[7:0]};
      SZ_H:    load_data_d = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      size_q  <= SZ_W;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      off_q   <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req && !misaligned) begin
            state_q <= BUS;
            cyc_q   <= 1'b1;
            we_q    <= mem_write_mem;
            adr_q   <= {addr_mem[31:2], 2'b00};
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            off_q   <= addr_mem[1:0];
            size_q  <= size_d;
            uns_q   <= fun3_mem[2];
            cnt_q   <= '0;
          end
        end
        BUS: begin
          cnt_q <= cnt_q + 8'd1;
          // Error beats a simultaneous ack; an ack in the last allowed cycle beats timeout.
          if (wb_err_i || (!wb_ack_i && cnt_q == TIMEOUT_M1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            cyc_q   <= 1'b0;
            state_q <= DONE;
          end else if (wb_ack_i) begin
            if (!we_q) rdata_q <= load_data_d;
            cyc_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        // Request inputs still show the retiring instruction here; ignore them.
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_pipl     = ~reset & (((state_q == IDLE) & req & ~misaligned) |
                                    (state_q == BUS));
  assign misaligned_mem = ~reset & (state_q == IDLE) & req & misaligned;
  assign bus_err_mem    = err_q;
  assign rdata_mem      = rdata_q;
  assign wb_cyc_o       = cyc_q;
  assign wb_stb_o       = cyc_q;
  assign wb_we_o        = we_q;
  assign wb_adr_o       = adr_q;
  assign wb_dat_o       = dat_q;
  assign wb_sel_o       = sel_q;

endmodule

// File: tb/tb_dmem_bus_master.sv
// Randomised scoreboard bench for dmem_bus_master: the driver pushes expected
// transfers, a negedge monitor pops and compares them as the DUT completes.
module tb_dmem_bus_master;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_mem, mem_write_mem;
  logic [2:0]  fun3_mem;
  logic [31:0] addr_mem, wdata_mem, rdata_mem;
  logic        stall_pipl, misaligned_mem, bus_err_mem;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i;

  always #5 clk = ~clk;

  dmem_bus_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .fun3_mem(fun3_mem), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .rdata_mem(rdata_mem), .stall_pipl(stall_pipl),
    .misaligned_mem(misaligned_mem), .bus_err_mem(bus_err_mem),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  typedef struct {
    bit          mis;
    bit          abort;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    logic        err;
    logic [31:0] rdata;
    int          cyc_n;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Gather the addressed bytes little-endian, then sign-extend arithmetically.
  function automatic logic [31:0] model_load(input logic [2:0] f, input int off,
                                             input logic [31:0] d);
    int     sz = size_of(f);
    longint v  = 0;
    for (int i = 0; i < sz; i++) v += longint'(d[8*(off+i) +: 8]) << (8*i);
    if (f[2] == 1'b0 && sz < 4 && v >= (longint'(1) << (8*sz - 1)))
      v -= longint'(1) << (8*sz);
    return v[31:0];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Outside BUS the slave lines must be ignored, so drive them with noise.
  task automatic spurious();
    wb_ack_i = 1'($urandom_range(0, 1));
    wb_err_i = ($urandom_range(0, 3) == 0);
    wb_dat_i = $urandom();
  endtask

  task automatic idle(input int n);
    mem_read_mem  = 1'b0;
    mem_write_mem = 1'b0;
    repeat (n) begin
      spurious();
      next_cycle();
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
  endtask

  // resp: 0 ack, 1 err, 2 ack+err together, 3 no response (timeout).
  // Returns at the start of the cycle after DONE with the request still held.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd, input int k,
                        input logic [31:0] rdat, input int resp);
    exp_t e;
    int   sz, off, last;
    e   = '{default: '0};
    sz  = size_of(f);
    off = int'(a[1:0]);
    mem_read_mem  = rd;
    mem_write_mem = wr;
    fun3_mem      = f;
    addr_mem      = a;
    wdata_mem     = wd;
    spurious();
    e.mis = (off % sz) != 0;
    if (e.mis) begin
      exp_q.push_back(e);
      next_cycle();
      return;
    end
    e.adr = a & ~32'h3;
    for (int i = 0; i < sz; i++) e.sel[off+i] = 1'b1;
    e.we  = wr;
    for (int j = 0; j < 4; j++) e.dat[8*j +: 8] = wd[8*(j % sz) +: 8];
    if (resp == 3) begin
      e.cyc_n = TO; e.err = 1'b1; e.rdata = '0;
    end else if (resp != 0) begin
      e.cyc_n = k;  e.err = 1'b1; e.rdata = '0;
    end else begin
      e.cyc_n = k;  e.err = 1'b0; e.rdata = wr ? model_rdata : model_load(f, off, rdat);
    end
    model_rdata = e.rdata;
    exp_q.push_back(e);
    last = e.cyc_n;
    for (int c = 1; c <= last; c++) begin
      next_cycle();
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = $urandom();
      if (c == last && resp != 3) begin
        wb_ack_i = (resp != 1);
        wb_err_i = (resp != 0);
        wb_dat_i = rdat;
      end
    end
    next_cycle();
    spurious();
    next_cycle();
  endtask

  // Monitor: compares every sampled cycle against the head of the scoreboard.
  initial begin : monitor
    bit          prev_cyc  = 1'b0;
    bit          rst_prev  = 1'b1;
    int          stall_run = 0;
    int          cyc_run   = 0;
    logic [31:0] cur_rdata = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst_prev) cur_rdata = '0;
      if (reset) begin
        stall_run = 0;
        cyc_run   = 0;
        prev_cyc  = (wb_cyc_o === 1'b1);
        rst_prev  = 1'b1;
        continue;
      end
      rst_prev = 1'b0;
      if (prev_cyc && wb_cyc_o === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.abort) begin
            check("abort_no_err", 32'(bus_err_mem), 32'd0);
            check("abort_rdata", rdata_mem, 32'd0);
          end else begin
            check("done_err", 32'(bus_err_mem), 32'(e.err));
            check("done_rdata", rdata_mem, e.rdata);
            check("done_stall", 32'(stall_pipl), 32'd0);
            check("stall_cycles", 32'(stall_run), 32'(e.cyc_n + 1));
            check("cyc_cycles", 32'(cyc_run), 32'(e.cyc_n));
          end
          cur_rdata = e.rdata;
        end
      end else begin
        check("no_err_pulse", 32'(bus_err_mem), 32'd0);
        check("rdata_hold", rdata_mem, cur_rdata);
      end
      if (wb_cyc_o !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cycle", 32'(wb_cyc_o), 32'd0);
        end else begin
          check("cyc_vs_alignment", 32'(wb_cyc_o), 32'(!exp_q[0].mis));
          check("bus_stb", 32'(wb_stb_o), 32'd1);
          check("bus_stall", 32'(stall_pipl), 32'd1);
          check("bus_adr", wb_adr_o, exp_q[0].adr);
          check("bus_sel", 32'(wb_sel_o), 32'(exp_q[0].sel));
          check("bus_we", 32'(wb_we_o), 32'(exp_q[0].we));
          if (exp_q[0].we) check("bus_dat", wb_dat_o, exp_q[0].dat);
        end
      end
      if (misaligned_mem !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_misaligned", 32'(misaligned_mem), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("misaligned_expected", 32'(misaligned_mem), 32'(e.mis));
          check("misaligned_no_cyc", 32'(wb_cyc_o), 32'd0);
          check("misaligned_no_stall", 32'(stall_pipl), 32'd0);
        end
      end
      stall_run = (stall_pipl === 1'b1) ? stall_run + 1 : 0;
      cyc_run   = (wb_cyc_o === 1'b1) ? cyc_run + 1 : 0;
      prev_cyc  = (wb_cyc_o === 1'b1);
    end
  end

  initial begin : driver
    exp_t e;
    reset         = 1'b1;
    mem_read_mem  = 1'b1;
    mem_write_mem = 1'b0;
    fun3_mem      = 3'b010;
    addr_mem      = 32'h100;
    wdata_mem     = 32'h0;
    wb_dat_i      = 32'h0;
    wb_ack_i      = 1'b0;
    wb_err_i      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_we", 32'(wb_we_o), 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_sel", 32'(wb_sel_o), 32'd0);
    check("rst_rdata", rdata_mem, 32'd0);
    check("rst_misaligned", 32'(misaligned_mem), 32'd0);
    check("rst_bus_err", 32'(bus_err_mem), 32'd0);
    check("rst_stall", 32'(stall_pipl), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Directed cases, first two back-to-back.
    access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF, 0);
    access(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 4, 32'h80FF_0000, 0);
    idle(1);
    access(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 4, 32'h80FF_0000, 0);
    idle(1);
    access(1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h1234_ABCD, 2, $urandom(), 0);
    idle(1);
    access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 1, 32'h0, 0);
    idle(1);
    access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 1, 32'h0, 3);
    idle(1);

    // Reset in cycle 2 of a pending LW, then an LW right after reset.
    e       = '{default: '0};
    e.abort = 1'b1;
    e.adr   = 32'h0000_0300;
    e.sel   = 4'hF;
    exp_q.push_back(e);
    mem_read_mem  = 1'b1;
    mem_write_mem = 1'b0;
    fun3_mem      = 3'b010;
    addr_mem      = 32'h0000_0300;
    wb_ack_i      = 1'b0;
    wb_err_i      = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset       = 1'b0;
    model_rdata = '0;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0, 2, 32'hCAFE_F00D, 0);
    idle(2);

    for (int n = 0; n < 80; n++) begin
      logic [2:0]  f;
      logic [31:0] a;
      int          kind, r, resp, sz;
      kind = $urandom_range(0, 2);
      f    = 3'($urandom_range(0, 7));
      sz   = size_of(f);
      a    = $urandom();
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      r    = $urandom_range(0, 9);
      resp = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      access(kind != 1, kind != 0, f, a, $urandom(), $urandom_range(1, TO),
             $urandom(), resp);
      r = $urandom_range(0, 2);
      if (r > 0) idle(r);
    end
    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
